// File: rtl/adc_cal_fma_feeder.sv
// adc_cal_fma_feeder
// Converts raw ADC codes exactly to IEEE-754 single precision and presents
// each converted sample, together with the gain and offset words that were
// current when it was accepted, as operands A, B and C of a fused multiply-add
// on three synchronized AXI-Stream channels with per-channel acceptance.
module adc_cal_fma_feeder #(
   parameter int ADC_BITS    = 24,   // raw code width, 2..24 so conversion is exact
   parameter bit SIGNED_CODE = 1'b0  // 0: unsigned/offset-binary, 1: two's complement
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [ADC_BITS-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic [31:0]         i_gain_tdata,
   input  logic                i_gain_tvalid,
   input  logic [31:0]         i_offset_tdata,
   input  logic                i_offset_tvalid,
   output logic [31:0]         m_a_axis_tdata,
   output logic                m_a_axis_tvalid,
   input  logic                m_a_axis_tready,
   output logic [31:0]         m_b_axis_tdata,
   output logic                m_b_axis_tvalid,
   input  logic                m_b_axis_tready,
   output logic [31:0]         m_c_axis_tdata,
   output logic                m_c_axis_tvalid,
   input  logic                m_c_axis_tready,
   output logic [31:0]         o_sample_cnt
);

   // Coefficient holding registers and "seen since reset" flags.
   logic [31:0] gain_reg;
   logic [31:0] offset_reg;
   logic        gain_seen;
   logic        offset_seen;
   logic        coef_ok;

   // Stage 1: magnitude, sign, leading-one position and coefficient snapshot.
   logic                s1_valid;
   logic [ADC_BITS-1:0] s1_mag;
   logic                s1_sign;
   logic [4:0]          s1_lead;
   logic [31:0]         s1_gain;
   logic [31:0]         s1_offset;

   // Output beat: beat_valid means a beat is held; the per-channel tvalid
   // registers drop individually once that channel has handshaken.
   logic beat_valid;

   // Combinational helpers.
   logic [ADC_BITS-1:0] in_mag;
   logic                in_sign;
   logic [4:0]          in_lead;
   logic [23:0]         norm;
   logic [7:0]          conv_exp;
   logic [31:0]         conv_word;
   logic                a_hs;
   logic                b_hs;
   logic                c_hs;
   logic                beat_done;
   logic                out_free;
   logic                s1_free;
   logic                s_hs;

   assign coef_ok = gain_seen & offset_seen;

   // The beat completes when every channel is either already accepted or
   // handshaking now; the output stage may then reload in the same cycle.
   assign a_hs      = m_a_axis_tvalid & m_a_axis_tready;
   assign b_hs      = m_b_axis_tvalid & m_b_axis_tready;
   assign c_hs      = m_c_axis_tvalid & m_c_axis_tready;
   assign beat_done = beat_valid
                    & (!m_a_axis_tvalid | a_hs)
                    & (!m_b_axis_tvalid | b_hs)
                    & (!m_c_axis_tvalid | c_hs);
   assign out_free  = !beat_valid | beat_done;
   assign s1_free   = !s1_valid | out_free;

   assign s_axis_tready = coef_ok & s1_free;
   assign s_hs          = s_axis_tvalid & s_axis_tready;

   // Front end: absolute value of the incoming code and its leading-one position.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      in_sign = 1'b0;
      in_mag  = s_axis_tdata;
      in_lead = '0;
      if (SIGNED_CODE && s_axis_tdata[ADC_BITS-1]) begin
         // -2^(ADC_BITS-1) negates to itself, which is the correct unsigned magnitude.
         in_sign = 1'b1;
         in_mag  = -s_axis_tdata;
      end
      for (int i = 0; i < ADC_BITS; i++) begin
         if (in_mag[i]) in_lead = 5'(i);
      end
   end

   // Back end: normalise so the leading one lands on bit 23, then pack.
   always_comb begin
      norm      = 24'(s1_mag) << (5'd23 - s1_lead);
      conv_exp  = 8'd127 + 8'(s1_lead);
      conv_word = {s1_sign, conv_exp, norm[22:0]};
      if (s1_mag == '0) conv_word = 32'h0000_0000;
   end

   // Coefficient latch, two-stage pipeline, output beat tracking and beat counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gain_reg        <= '0;
         offset_reg      <= '0;
         gain_seen       <= 1'b0;
         offset_seen     <= 1'b0;
         s1_valid        <= 1'b0;
         s1_mag          <= '0;
         s1_sign         <= 1'b0;
         s1_lead         <= '0;
         s1_gain         <= '0;
         s1_offset       <= '0;
         beat_valid      <= 1'b0;
         m_a_axis_tvalid <= 1'b0;
         m_b_axis_tvalid <= 1'b0;
         m_c_axis_tvalid <= 1'b0;
         m_a_axis_tdata  <= '0;
         m_b_axis_tdata  <= '0;
         m_c_axis_tdata  <= '0;
         o_sample_cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (i_gain_tvalid) begin
            gain_reg  <= i_gain_tdata;
            gain_seen <= 1'b1;
         end
         if (i_offset_tvalid) begin
            offset_reg  <= i_offset_tdata;
            offset_seen <= 1'b1;
         end

         if (s1_free) begin
            s1_valid <= s_hs;
            if (s_hs) begin
               s1_mag    <= in_mag;
               s1_sign   <= SIGNED_CODE ? in_sign : 1'b0;
               s1_lead   <= in_lead;
               // A coefficient arriving in the acceptance cycle is the one the sample uses.
               s1_gain   <= i_gain_tvalid   ? i_gain_tdata   : gain_reg;
               s1_offset <= i_offset_tvalid ? i_offset_tdata : offset_reg;
            end
         end

         if (out_free) begin
            beat_valid      <= s1_valid;
            m_a_axis_tvalid <= s1_valid;
            m_b_axis_tvalid <= s1_valid;
            m_c_axis_tvalid <= s1_valid;
            if (s1_valid) begin
               m_a_axis_tdata <= conv_word;
               m_b_axis_tdata <= s1_gain;
               m_c_axis_tdata <= s1_offset;
            end
         end else begin
            if (a_hs) m_a_axis_tvalid <= 1'b0;
            if (b_hs) m_b_axis_tvalid <= 1'b0;
            if (c_hs) m_c_axis_tvalid <= 1'b0;
         end

         if (beat_done) o_sample_cnt <= o_sample_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_adc_cal_fma_feeder.sv
// Directed testbench for adc_cal_fma_feeder: a 24-bit unsigned instance and
// a 16-bit two's-complement instance share clock, reset and coefficients.
module tb_adc_cal_fma_feeder;

   localparam logic [31:0] G1 = 32'h35A0_0000;
   localparam logic [31:0] G2 = 32'h3920_0000;
   localparam logic [31:0] G3 = 32'h3F80_0000;
   localparam logic [31:0] O1 = 32'hC120_0000;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [31:0] gain, offset;
   logic        gain_v, offset_v;

   // 24-bit unsigned instance
   logic [23:0] s_tdata;
   logic        s_tvalid, s_tready;
   logic [31:0] a_data, b_data, c_data, cnt;
   logic        a_v, b_v, c_v, a_r, b_r, c_r;

   // 16-bit signed instance (output readies held high)
   logic [15:0] s16_tdata;
   logic        s16_tvalid, s16_tready;
   logic [31:0] a16_data, b16_data, c16_data, cnt16;
   logic        a16_v, b16_v, c16_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adc_cal_fma_feeder #(.ADC_BITS(24), .SIGNED_CODE(1'b0)) u_dut (
      .i_clk(clk), .i_rst(i_rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .i_gain_tdata(gain), .i_gain_tvalid(gain_v),
      .i_offset_tdata(offset), .i_offset_tvalid(offset_v),
      .m_a_axis_tdata(a_data), .m_a_axis_tvalid(a_v), .m_a_axis_tready(a_r),
      .m_b_axis_tdata(b_data), .m_b_axis_tvalid(b_v), .m_b_axis_tready(b_r),
      .m_c_axis_tdata(c_data), .m_c_axis_tvalid(c_v), .m_c_axis_tready(c_r),
      .o_sample_cnt(cnt)
   );

   adc_cal_fma_feeder #(.ADC_BITS(16), .SIGNED_CODE(1'b1)) u_dut16 (
      .i_clk(clk), .i_rst(i_rst),
      .s_axis_tdata(s16_tdata), .s_axis_tvalid(s16_tvalid), .s_axis_tready(s16_tready),
      .i_gain_tdata(gain), .i_gain_tvalid(gain_v),
      .i_offset_tdata(offset), .i_offset_tvalid(offset_v),
      .m_a_axis_tdata(a16_data), .m_a_axis_tvalid(a16_v), .m_a_axis_tready(1'b1),
      .m_b_axis_tdata(b16_data), .m_b_axis_tvalid(b16_v), .m_b_axis_tready(1'b1),
      .m_c_axis_tdata(c16_data), .m_c_axis_tvalid(c16_v), .m_c_axis_tready(1'b1),
      .o_sample_cnt(cnt16)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      s_tvalid = 1'b0; s16_tvalid = 1'b0; gain_v = 1'b0; offset_v = 1'b0;
      a_r = 1'b0; b_r = 1'b0; c_r = 1'b0;
      step();
      i_rst = 1'b0;
   endtask

   task automatic load_coef(input logic [31:0] g, input logic [31:0] o);
      gain = g; gain_v = 1'b1; offset = o; offset_v = 1'b1;
      step();
      gain_v = 1'b0; offset_v = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      s_tvalid = 1'b0; s16_tvalid = 1'b0; gain_v = 1'b0; offset_v = 1'b0;
      gain = '0; offset = '0; s_tdata = '0; s16_tdata = '0;
      a_r = 1'b1; b_r = 1'b1; c_r = 1'b1;
      repeat (2) step();
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000) begin
         errors++; $display("FAIL reset_tvalid: got %b expected 000", {a_v, b_v, c_v});
      end
      checks++;
      if ({a_data, b_data, c_data} !== 96'h0) begin
         errors++; $display("FAIL reset_tdata: got %h expected 0", {a_data, b_data, c_data});
      end
      checks++;
      if (cnt !== 32'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt);
      end
      i_rst = 1'b0;
      s_tvalid = 1'b1; s_tdata = 24'h000123;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (s_tready !== 1'b0 || a_v !== 1'b0) begin
            errors++; $display("FAIL no_coef_wait[%0d]: got tready=%b a_v=%b expected 0 0", k, s_tready, a_v);
         end
      end
      gain = G1; gain_v = 1'b1; offset = O1; offset_v = 1'b1;
      #1;
      checks++;
      if (s_tready !== 1'b0) begin
         errors++; $display("FAIL coef_same_cycle_tready: got %b expected 0", s_tready);
      end
      step();
      gain_v = 1'b0; offset_v = 1'b0;
      checks++;
      if (s_tready !== 1'b1) begin
         errors++; $display("FAIL coef_tready_rise: got %b expected 1", s_tready);
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_unsigned_conv();
      logic [23:0] codes [4];
      logic [31:0] expa  [4];
      codes = '{24'h000000, 24'h000001, 24'h800000, 24'hFFFFFF};
      expa  = '{32'h0000_0000, 32'h3F80_0000, 32'h4B00_0000, 32'h4B7F_FFFF};
      do_reset();
      load_coef(G1, O1);
      a_r = 1'b1; b_r = 1'b1; c_r = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            s_tvalid = 1'b1; s_tdata = codes[k];
            #1;
            checks++;
            if (s_tready !== 1'b1) begin
               errors++; $display("FAIL u_tready[%0d]: got %b expected 1", k, s_tready);
            end
         end else begin
            s_tvalid = 1'b0;
         end
         step();
         if (k >= 1 && k <= 4) begin
            checks++;
            if (a_v !== 1'b1 || a_data !== expa[k-1]) begin
               errors++; $display("FAIL u_conv[%0d]: got v=%b %h expected v=1 %h", k-1, a_v, a_data, expa[k-1]);
            end
            checks++;
            if (b_v !== 1'b1 || c_v !== 1'b1 || b_data !== G1 || c_data !== O1) begin
               errors++; $display("FAIL u_coef[%0d]: got b=%h c=%h expected %h %h", k-1, b_data, c_data, G1, O1);
            end
         end
         if (k == 5) begin
            checks++;
            if (cnt !== 32'd4 || a_v !== 1'b0) begin
               errors++; $display("FAIL u_cnt: got cnt=%0d a_v=%b expected 4 0", cnt, a_v);
            end
         end
      end
   endtask

   task automatic test_signed_conv();
      logic [15:0] codes [3];
      logic [31:0] expa  [3];
      codes = '{16'h8000, 16'h7FFF, 16'hFFFF};
      expa  = '{32'hC700_0000, 32'h46FF_FE00, 32'hBF80_0000};
      do_reset();
      load_coef(G1, O1);
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            s16_tvalid = 1'b1; s16_tdata = codes[k];
         end else begin
            s16_tvalid = 1'b0;
         end
         step();
         if (k >= 1 && k <= 3) begin
            checks++;
            if (a16_v !== 1'b1 || a16_data !== expa[k-1]) begin
               errors++; $display("FAIL s_conv[%0d]: got v=%b %h expected v=1 %h", k-1, a16_v, a16_data, expa[k-1]);
            end
         end
         if (k == 4) begin
            checks++;
            if (cnt16 !== 32'd3 || b16_data !== G1 || c16_data !== O1) begin
               errors++; $display("FAIL s_end: got cnt=%0d b=%h c=%h expected 3 %h %h", cnt16, b16_data, c16_data, G1, O1);
            end
         end
      end
   endtask

   task automatic test_per_channel();
      logic exp_a, exp_c, exp_rdy;
      do_reset();
      load_coef(G1, O1);
      s_tvalid = 1'b1; s_tdata = 24'd5;
      step();
      s_tdata = 24'd6;
      step();
      s_tdata = 24'd7;
      for (int cyc = 0; cyc < 6; cyc++) begin
         a_r = (cyc == 0); c_r = (cyc == 3); b_r = (cyc == 5);
         #1;
         exp_a = (cyc == 0); exp_c = (cyc <= 3); exp_rdy = (cyc == 5);
         checks++;
         if (a_v !== exp_a || b_v !== 1'b1 || c_v !== exp_c) begin
            errors++; $display("FAIL pc_valid[%0d]: got abc=%b%b%b expected %b1%b", cyc, a_v, b_v, c_v, exp_a, exp_c);
         end
         checks++;
         if (a_data !== 32'h40A0_0000 || cnt !== 32'd0) begin
            errors++; $display("FAIL pc_hold[%0d]: got a=%h cnt=%0d expected 40a00000 0", cyc, a_data, cnt);
         end
         checks++;
         if (s_tready !== exp_rdy) begin
            errors++; $display("FAIL pc_tready[%0d]: got %b expected %b", cyc, s_tready, exp_rdy);
         end
         step();
      end
      s_tvalid = 1'b0; a_r = 1'b0; b_r = 1'b0; c_r = 1'b0;
      checks++;
      if (cnt !== 32'd1 || {a_v, b_v, c_v} !== 3'b111 || a_data !== 32'h40C0_0000) begin
         errors++; $display("FAIL pc_next: got cnt=%0d abc=%b a=%h expected 1 111 40c00000", cnt, {a_v, b_v, c_v}, a_data);
      end
      a_r = 1'b1; b_r = 1'b1; c_r = 1'b1;
      step();
      checks++;
      if (cnt !== 32'd2 || a_v !== 1'b1 || a_data !== 32'h40E0_0000) begin
         errors++; $display("FAIL pc_third: got cnt=%0d v=%b a=%h expected 2 1 40e00000", cnt, a_v, a_data);
      end
      step();
      checks++;
      if (cnt !== 32'd3 || a_v !== 1'b0) begin
         errors++; $display("FAIL pc_drain: got cnt=%0d v=%b expected 3 0", cnt, a_v);
      end
   endtask

   task automatic test_coef_change();
      logic [31:0] exp_b;
      logic [31:0] exp_a;
      do_reset();
      load_coef(G1, O1);
      a_r = 1'b1; b_r = 1'b1; c_r = 1'b1;
      for (int k = 0; k < 7; k++) begin
         s_tvalid = 1'b0; gain_v = 1'b0;
         case (k)
            0: begin s_tvalid = 1'b1; s_tdata = 24'd1; end
            1: begin s_tvalid = 1'b1; s_tdata = 24'd2; end
            2: begin gain_v = 1'b1; gain = G2; end
            3: begin s_tvalid = 1'b1; s_tdata = 24'd3; end
            4: begin s_tvalid = 1'b1; s_tdata = 24'd4; gain_v = 1'b1; gain = G3; end
            default: ;
         endcase
         step();
         exp_b = G1; exp_a = 32'h0;
         case (k)
            1: begin exp_a = 32'h3F80_0000; exp_b = G1; end
            2: begin exp_a = 32'h4000_0000; exp_b = G1; end
            4: begin exp_a = 32'h4040_0000; exp_b = G2; end
            5: begin exp_a = 32'h4080_0000; exp_b = G3; end
            default: ;
         endcase
         if (k == 1 || k == 2 || k == 4 || k == 5) begin
            checks++;
            if (a_v !== 1'b1 || a_data !== exp_a || b_data !== exp_b) begin
               errors++; $display("FAIL cc_beat[%0d]: got v=%b a=%h b=%h expected 1 %h %h", k, a_v, a_data, b_data, exp_a, exp_b);
            end
         end
         if (k == 3 || k == 6) begin
            checks++;
            if (a_v !== 1'b0) begin
               errors++; $display("FAIL cc_bubble[%0d]: got v=%b expected 0", k, a_v);
            end
         end
      end
      gain_v = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_coef(G1, O1);
      a_r = 1'b1; b_r = 1'b1; c_r = 1'b1;
      s_tvalid = 1'b1; s_tdata = 24'd1;
      step();
      s_tdata = 24'd2;
      step();
      s_tvalid = 1'b0;
      step();
      a_r = 1'b1; b_r = 1'b0; c_r = 1'b0;
      step();
      checks++;
      if (cnt !== 32'd1 || {a_v, b_v, c_v} !== 3'b011) begin
         errors++; $display("FAIL rm_partial: got cnt=%0d abc=%b expected 1 011", cnt, {a_v, b_v, c_v});
      end
      i_rst = 1'b1; a_r = 1'b0;
      step();
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000 || cnt !== 32'd0 || s_tready !== 1'b0) begin
         errors++; $display("FAIL rm_reset: got abc=%b cnt=%0d tready=%b expected 000 0 0", {a_v, b_v, c_v}, cnt, s_tready);
      end
      checks++;
      if ({a_data, b_data, c_data} !== 96'h0) begin
         errors++; $display("FAIL rm_tdata: got %h expected 0", {a_data, b_data, c_data});
      end
      i_rst = 1'b0;
      s_tvalid = 1'b1; s_tdata = 24'd9;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (s_tready !== 1'b0 || a_v !== 1'b0) begin
            errors++; $display("FAIL rm_no_coef[%0d]: got tready=%b a_v=%b expected 0 0", k, s_tready, a_v);
         end
      end
      s_tvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_unsigned_conv();
      test_signed_conv();
      test_per_channel();
      test_coef_change();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adc_cal_fma_feeder.md
Name: adc_cal_fma_feeder

Overview:
Sits between the ADC capture logic and the floating-point fused multiply-add (A*B+C) stage that applies ADC calibration.
- Converts each raw ADC code exactly to IEEE-754 single precision.
- Pairs each converted sample with the gain and offset words current when the sample was accepted.
- Issues the three operands to the FMA as three synchronized AXI-Stream channels, with per-channel acceptance tracking.

Parameters:
ADC_BITS, 24, raw code width; legal range 2..24, so conversion is always exact.
SIGNED_CODE, 0, 0 = offset-binary/unsigned code; 1 = two's-complement code.

Ports:
i_clk  in  1  clock, 200 MHz domain
i_rst  in  1  synchronous active-high reset
s_axis_tdata  in  ADC_BITS  raw ADC code
s_axis_tvalid  in  1  raw sample valid
s_axis_tready  out  1  raw sample accepted when tvalid&tready
i_gain_tdata  in  32  float gain word
i_gain_tvalid  in  1  gain word valid
i_offset_tdata  in  32  float offset word
i_offset_tvalid  in  1  offset word valid
m_a_axis_tdata  out  32  converted sample (FMA operand A)
m_a_axis_tvalid  out  1
m_a_axis_tready  in  1
m_b_axis_tdata  out  32  gain (operand B)
m_b_axis_tvalid  out  1
m_b_axis_tready  in  1
m_c_axis_tdata  out  32  offset (operand C)
m_c_axis_tvalid  out  1
m_c_axis_tready  in  1
o_sample_cnt  out  32  count of completed output beats, wraps 0xFFFFFFFF->0

Behaviour:
- Reset (i_rst sampled high at a clock edge):
  - All tvalid outputs 0, s_axis_tready 0, all tdata 0, o_sample_cnt 0.
  - Pipeline valid flags and coefficient registers cleared; coef_ok = 0.
  - Reset mid-operation discards any in-flight samples and partially accepted beats.
- Coefficient latch:
  - gain_reg and offset_reg update on any cycle their tvalid is 1.
  - coef_ok sets once both have been seen at least once since reset.
  - s_axis_tready = coef_ok & !stall, so no sample is accepted before both coefficients exist.
- Stage 1 (on input handshake):
  - Register the magnitude.
  - Register the sign, only when SIGNED_CODE=1.
  - Snapshot gain_reg/offset_reg; a coefficient change after acceptance never affects that sample.
  - Compute the leading-one position.
- Stage 2:
  - Normalise the magnitude; mantissa = bits below the leading one, left-aligned into 23 bits.
  - exponent = 127 + leading-one position; pack sign|exponent|mantissa.
  - Magnitude 0 -> 0x00000000 (positive zero).
  - Signed minimum (-2^(ADC_BITS-1)) converts exactly.
- Latency: input handshake at cycle t -> all three m_*_tvalid high at t+2 when not stalled.
- Throughput: 1 sample/cycle when all treadys are held high.
- Output beat:
  - A, B and C tvalid assert together, with tdata stable until that channel handshakes.
  - Each channel drops its own tvalid after its handshake (per-channel done flag).
  - The beat completes on the cycle the last outstanding channel handshakes; done flags clear and o_sample_cnt increments.
  - The next beat may load that same cycle, so there is no bubble.
- Stall:
  - The output stage holds while its beat is incomplete.
  - Stage 2 may advance only if the output is empty or completing this cycle.
  - Stage 1 follows the same rule against stage 2.
  - s_axis_tready falls combinationally only through pipeline-full-and-blocked; no sample is lost or duplicated.
- Simultaneous events:
  - Coefficient update in the same cycle as sample acceptance: the sample snapshots the NEW value.
  - All three treadys high on the first valid cycle: the beat completes in one cycle.
- No arithmetic on gain/offset: passed bit-exact.

Test Plan:
1. Reset release with no coefficient valid, s_axis_tvalid=1 -> s_axis_tready stays 0; no m_*_tvalid. Then gain=0x35A00000 and offset=0xC1200000 pulse once -> tready rises the next cycle.
2. ADC_BITS=24, SIGNED_CODE=0, treadys high; codes 0x000000, 0x000001, 0x800000, 0xFFFFFF back-to-back -> A = 0x00000000, 0x3F800000, 0x4B000000, 0x4B7FFFFF on consecutive cycles at latency 2. B = 0x35A00000, C = 0xC1200000 each beat; o_sample_cnt ends at 4.
3. ADC_BITS=16, SIGNED_CODE=1; codes 0x8000, 0x7FFF, 0xFFFF -> A = 0xC7000000, 0x46FFFE00, 0xBF800000.
4. Per-channel acceptance: A tready at cycle 0, C at cycle 3, B at cycle 5 -> each tvalid drops after its own handshake. The beat completes at cycle 5, o_sample_cnt +1, the next beat is presented at cycle 6, and upstream receives no tready while the pipeline is full.
5. Gain changes 0x35A00000 -> 0x39200000 while two samples are in flight -> in-flight beats carry 0x35A00000; the first sample accepted after the change carries 0x39200000.
6. Assert i_rst during a partially accepted beat -> all tvalid 0 and o_sample_cnt 0 next cycle. After release, tready stays 0 until new coefficients arrive.
